// File: rtl/cpu_pc.sv
// Program counter: WIDTH-bit register with synchronous load, fixed-step
// increment that wraps modulo 2^WIDTH, and asynchronous active-low reset.
module cpu_pc #(
   parameter int unsigned           WIDTH       = 8,
   parameter logic [WIDTH-1:0]      RESET_VALUE = '0,
   parameter int unsigned           STEP        = 1
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             LD,
   input  logic [WIDTH-1:0] ADDR,
   output logic [WIDTH-1:0] PC_OUT
);

   // Step truncated to the counter width so the add wraps naturally.
   localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

   logic [WIDTH-1:0] pc;
   logic [WIDTH-1:0] pc_next_c;

   // Next value: a load wins over the increment.
   always_comb begin
      pc_next_c = pc + STEP_W;
      if (LD) begin
         pc_next_c = ADDR;
      end
   end

   // Counter register; reset forces RESET_VALUE immediately.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         pc <= RESET_VALUE;
      end else begin
         pc <= pc_next_c;
      end
   end

   assign PC_OUT = pc;

endmodule

// File: tb/tb_cpu_pc.sv
// Directed self-checking bench for cpu_pc (WIDTH=8, RESET_VALUE=0, STEP=1).
module tb_cpu_pc;

   localparam int unsigned WIDTH = 8;

   logic             CLK;
   logic             RST;
   logic             LD;
   logic [WIDTH-1:0] ADDR;
   logic [WIDTH-1:0] PC_OUT;

   int n_cmp;
   int n_err;

   cpu_pc #(
      .WIDTH       (WIDTH),
      .RESET_VALUE (8'h00),
      .STEP        (1)
   ) dut (
      .CLK    (CLK),
      .RST    (RST),
      .LD     (LD),
      .ADDR   (ADDR),
      .PC_OUT (PC_OUT)
   );

   // Free-running clock, 10 time-unit period.
   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // Compare one observed value with its expected value.
   task automatic check(input string tag, input logic [WIDTH-1:0] got,
                        input logic [WIDTH-1:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", tag, got, exp, $time);
      end
   endtask

   // Advance one rising edge and return at the following falling edge.
   task automatic tick();
      @(posedge CLK);
      @(negedge CLK);
   endtask

   logic [WIDTH-1:0] exp_pc;

   initial begin
      n_cmp = 0;
      n_err = 0;
      RST   = 1'b1;
      LD    = 1'b0;
      ADDR  = 8'h00;

      // Asynchronous reset between edges takes effect immediately.
      @(negedge CLK);
      #2;
      RST = 1'b0;
      #1;
      check("reset_immediate", PC_OUT, 8'h00);

      // Edges with LD high are ignored while reset is held.
      LD   = 1'b1;
      ADDR = 8'h55;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("reset_hold", PC_OUT, 8'h00);
      end

      // Release reset and count 0x01..0x0A.
      LD  = 1'b0;
      RST = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         tick();
         check("count_from_reset", PC_OUT, 8'(i));
      end

      // Load 0xA7; LD/ADDR do not reach the output before the edge.
      ADDR = 8'hA7;
      LD   = 1'b1;
      #1;
      check("load_latency", PC_OUT, 8'h0A);
      tick();
      check("load_a7", PC_OUT, 8'hA7);
      LD = 1'b0;
      exp_pc = 8'hA7;
      for (int i = 0; i < 20; i++) begin
         tick();
         exp_pc = exp_pc + 8'h01;
         check("count_after_load", PC_OUT, exp_pc);
      end
      check("count_end_bb", PC_OUT, 8'hBB);

      // Load 0xFE and wrap through 0xFF to 0x00, 0x01.
      ADDR = 8'hFE;
      LD   = 1'b1;
      tick();
      check("load_fe", PC_OUT, 8'hFE);
      LD = 1'b0;
      tick();
      check("wrap_ff", PC_OUT, 8'hFF);
      tick();
      check("wrap_00", PC_OUT, 8'h00);
      tick();
      check("wrap_01", PC_OUT, 8'h01);

      // ADDR toggling with LD low has no effect on the count.
      ADDR = 8'h99;
      tick();
      check("addr_ignored_a", PC_OUT, 8'h02);
      ADDR = 8'h3C;
      tick();
      check("addr_ignored_b", PC_OUT, 8'h03);
      ADDR = 8'hFF;
      tick();
      check("addr_ignored_c", PC_OUT, 8'h04);

      // LD held high reloads the same address every cycle.
      ADDR = 8'h33;
      LD   = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("load_held_33", PC_OUT, 8'h33);
      end
      LD = 1'b0;
      tick();
      check("resume_after_held", PC_OUT, 8'h34);

      // Reset mid-count aborts immediately, between edges.
      tick();
      check("pre_abort", PC_OUT, 8'h35);
      #2;
      RST = 1'b0;
      #1;
      check("abort_mid_count", PC_OUT, 8'h00);
      @(negedge CLK);
      RST = 1'b1;
      tick();
      check("restart_after_abort", PC_OUT, 8'h01);

      // Reset asserted on a rising edge together with a load of 0x55.
      ADDR = 8'h55;
      LD   = 1'b1;
      @(posedge CLK);
      RST = 1'b0;
      #1;
      check("reset_vs_load_edge", PC_OUT, 8'h00);
      @(negedge CLK);
      check("reset_vs_load_hold", PC_OUT, 8'h00);
      tick();
      check("reset_vs_load_hold2", PC_OUT, 8'h00);
      LD  = 1'b0;
      RST = 1'b1;
      tick();
      check("first_after_release", PC_OUT, 8'h01);

      // Load immediately after release starts from the loaded address.
      ADDR = 8'hC0;
      LD   = 1'b1;
      tick();
      check("load_c0", PC_OUT, 8'hC0);
      LD = 1'b0;
      tick();
      check("count_c1", PC_OUT, 8'hC1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   // Watchdog so the run always terminates.
   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1);
   end

endmodule
